// File: rtl/cond_issue_ctrl_pkg.sv
// Shared definitions for the conditional-issue controller: condition codes,
// status-register bit positions and the issue FSM state type.
package cond_issue_ctrl_pkg;

   // Condition field encodings
   localparam logic [3:0] COND_EQ = 4'h0;  // z
   localparam logic [3:0] COND_NE = 4'h1;  // ~z
   localparam logic [3:0] COND_CS = 4'h2;  // c
   localparam logic [3:0] COND_CC = 4'h3;  // ~c
   localparam logic [3:0] COND_MI = 4'h4;  // n
   localparam logic [3:0] COND_PL = 4'h5;  // ~n
   localparam logic [3:0] COND_VS = 4'h6;  // v
   localparam logic [3:0] COND_VC = 4'h7;  // ~v
   localparam logic [3:0] COND_HI = 4'h8;  // c & ~z
   localparam logic [3:0] COND_LS = 4'h9;  // ~c | z
   localparam logic [3:0] COND_GE = 4'hA;  // n == v
   localparam logic [3:0] COND_LT = 4'hB;  // n != v
   localparam logic [3:0] COND_GT = 4'hC;  // ~z & (n == v)
   localparam logic [3:0] COND_LE = 4'hD;  // z | (n != v)
   localparam logic [3:0] COND_AL = 4'hE;  // always
   localparam logic [3:0] COND_NV = 4'hF;  // never

   // Bit positions inside the {z,c,n,v} status register
   localparam int SR_Z = 3;
   localparam int SR_C = 2;
   localparam int SR_N = 1;
   localparam int SR_V = 0;

   // Width of the in-flight flag-setter counter (MAX_INFLIGHT is at most 7)
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      ISSUE = 2'd2
   } state_t;

   // Always/never conditions do not read the flags, so they never wait on
   // an outstanding flag writeback.
   function automatic logic cond_is_flag_free(input logic [3:0] cond);
      return (cond == COND_AL) || (cond == COND_NV);
   endfunction

endpackage

// File: rtl/cond_issue_ctrl_if.sv
// Decode/execute/writeback signal bundle of the conditional-issue controller.
// The master side drives decode, execute-ready and writeback; the slave side
// is the controller itself.
interface cond_issue_ctrl_if;

   logic       in_valid;
   logic [3:0] in_cond;
   logic       in_set_flags;
   logic       in_ready;
   logic       out_valid;
   logic       out_exec;
   logic       out_set_flags;
   logic       out_ready;
   logic       wb_flag_valid;
   logic [3:0] wb_flags;
   logic       flush;
   logic [3:0] sr;
   logic       wb_err;

   modport master (
      output in_valid, in_cond, in_set_flags, out_ready,
             wb_flag_valid, wb_flags, flush,
      input  in_ready, out_valid, out_exec, out_set_flags, sr, wb_err
   );

   modport slave (
      input  in_valid, in_cond, in_set_flags, out_ready,
             wb_flag_valid, wb_flags, flush,
      output in_ready, out_valid, out_exec, out_set_flags, sr, wb_err
   );

endinterface

// File: rtl/cond_issue_ctrl_cond_eval.sv
// Combinational condition evaluator: decides whether a condition field
// passes against a {z,c,n,v} status value.
module cond_eval
   import cond_issue_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] sr,
   output logic       pass
);

   logic z;
   logic c;
   logic n;
   logic v;

   assign z = sr[SR_Z];
   assign c = sr[SR_C];
   assign n = sr[SR_N];
   assign v = sr[SR_V];

   // One entry per condition encoding
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Conditional-issue controller: holds one decoded instruction until its
// condition can be evaluated against settled flags, issues it with an
// execute/annul decision, and tracks flag-setting instructions that are
// still waiting for their status writeback.
module cond_issue_ctrl
   import cond_issue_ctrl_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3
)(
   input  logic              clk,
   input  logic              rst,
   cond_issue_ctrl_if.slave  bus
);

   state_t           state_reg;
   state_t           state_next;
   logic [3:0]       cond_reg;
   logic             set_flags_reg;
   logic             out_exec_reg;
   logic             out_set_flags_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic [3:0]       sr_reg;
   logic             wb_err_reg;

   logic             capture;
   logic             issue;
   logic             fire;
   logic             dep_ok;
   logic             cap_ok;
   logic             cond_pass;
   logic             cnt_inc;
   logic             cnt_dec;

   // Single condition evaluator, always looking at the held condition and
   // the architectural status register as it stands this cycle.
   cond_eval u_cond_eval (
      .cond (cond_reg),
      .sr   (sr_reg),
      .pass (cond_pass)
   );

   // A flag-reading condition must wait for every outstanding flag-setter;
   // a flag-setter also needs a free in-flight slot.
   assign dep_ok = cond_is_flag_free(cond_reg) || (count_reg == '0);
   assign cap_ok = !set_flags_reg || (count_reg < CNT_W'(MAX_INFLIGHT));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake decode; flush overrides every transition
   always_comb begin
      state_next    = state_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      capture       = 1'b0;
      issue         = 1'b0;
      fire          = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (dep_ok && cap_ok) begin
               issue      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               fire       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.flush) begin
         state_next = IDLE;
         capture    = 1'b0;
         issue      = 1'b0;
         fire       = 1'b0;
      end
   end

   // In-flight count update; an increment and decrement together cancel,
   // and a writeback with nothing outstanding leaves the count at zero.
   assign cnt_inc = fire && out_set_flags_reg;
   assign cnt_dec = bus.wb_flag_valid;

   always_comb begin
      count_next = count_reg;
      if (cnt_inc && !cnt_dec) begin
         count_next = count_reg + 1'b1;
      end else if (!cnt_inc && cnt_dec && (count_reg != '0)) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Held instruction, issue decision, flag bookkeeping and status register
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_reg          <= '0;
         set_flags_reg     <= 1'b0;
         out_exec_reg      <= 1'b0;
         out_set_flags_reg <= 1'b0;
         count_reg         <= '0;
         sr_reg            <= '0;
         wb_err_reg        <= 1'b0;
      end else begin
         // The status register always follows a writeback, even under flush
         if (bus.wb_flag_valid) begin
            sr_reg <= bus.wb_flags;
         end
         if (bus.flush) begin
            count_reg <= '0;
         end else begin
            count_reg <= count_next;
            if (bus.wb_flag_valid && (count_reg == '0)) begin
               wb_err_reg <= 1'b1;
            end
         end
         if (capture) begin
            cond_reg      <= bus.in_cond;
            set_flags_reg <= bus.in_set_flags;
         end
         // Annulled instructions never claim an in-flight slot
         if (issue) begin
            out_exec_reg      <= cond_pass;
            out_set_flags_reg <= set_flags_reg && cond_pass;
         end
      end
   end

   assign bus.out_exec      = out_exec_reg;
   assign bus.out_set_flags = out_set_flags_reg;
   assign bus.sr            = sr_reg;
   assign bus.wb_err        = wb_err_reg;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Scoreboard bench for cond_issue_ctrl: a transaction-level reference model
// predicts each issued instruction and the observable handshake state, and a
// negedge monitor compares the DUT against it.
module tb_cond_issue_ctrl;

   localparam int MAXI = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cond_issue_ctrl_if bus ();

   cond_issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic exec;
      logic setf;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state: one held instruction, one presented instruction
   bit         m_hold;
   bit [3:0]   m_cond;
   bit         m_setf;
   bit         m_pres;
   bit         m_pres_setf;
   int         m_count;
   bit [3:0]   m_sr;
   bit         m_err;

   // Condition table folded as "base test, optionally inverted by bit 0"
   function automatic bit ref_cond(input bit [3:0] cond, input bit [3:0] flags);
      bit z, c, n, v, base;
      z = flags[3]; c = flags[2]; n = flags[1]; v = flags[0];
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return cond[0] ? !base : base;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model advances on each rising edge
   always @(posedge clk) begin : model
      bit fire;
      bit pass;
      int cnt;
      if (rst) begin
         m_hold <= 0; m_cond <= 0; m_setf <= 0; m_pres <= 0; m_pres_setf <= 0;
         m_count <= 0; m_sr <= 0; m_err <= 0;
         exp_q.delete();
      end else begin
         fire = m_pres && bus.out_ready;
         cnt  = m_count;
         if (bus.wb_flag_valid) m_sr <= bus.wb_flags;
         if (bus.flush) begin
            m_count <= 0; m_hold <= 0; m_pres <= 0;
         end else begin
            if (bus.wb_flag_valid && cnt == 0) m_err <= 1;
            if (fire && m_pres_setf && !bus.wb_flag_valid) m_count <= cnt + 1;
            else if (!(fire && m_pres_setf) && bus.wb_flag_valid && cnt > 0) m_count <= cnt - 1;
            if (fire) m_pres <= 0;
            if (m_hold && (m_cond >= 4'hE || cnt == 0) && (!m_setf || cnt < MAXI)) begin
               pass = ref_cond(m_cond, m_sr);
               exp_q.push_back('{exec: pass, setf: m_setf && pass});
               m_pres      <= 1;
               m_pres_setf <= m_setf && pass;
               m_hold      <= 0;
            end
            if (!m_hold && !m_pres && bus.in_valid) begin
               m_hold <= 1;
               m_cond <= bus.in_cond;
               m_setf <= bus.in_set_flags;
            end
         end
      end
   end

   // Monitor: compare visible state every cycle, pop on each presented issue
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         chk("in_ready", bus.in_ready, !m_hold && !m_pres);
         chk("out_valid", bus.out_valid, m_pres);
         chk("sr", bus.sr, m_sr);
         chk("wb_err", bus.wb_err, m_err);
         if (bus.out_valid && (bus.out_ready || bus.flush)) begin
            if (exp_q.size() == 0) begin
               chk("issue_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_exec", bus.out_exec, e.exec);
               chk("out_set_flags", bus.out_set_flags, e.setf);
            end
         end
      end
   end

   task automatic drive(input bit iv, input bit [3:0] c, input bit sf, input bit ordy,
                        input bit wbv, input bit [3:0] wbf, input bit fl);
      bus.in_valid      = iv;
      bus.in_cond       = c;
      bus.in_set_flags  = sf;
      bus.out_ready     = ordy;
      bus.wb_flag_valid = wbv;
      bus.wb_flags      = wbf;
      bus.flush         = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) drive(0, 4'h0, 0, ordy, 0, 4'h0, 0);
   endtask

   initial begin
      bus.in_valid = 0; bus.in_cond = 0; bus.in_set_flags = 0; bus.out_ready = 0;
      bus.wb_flag_valid = 0; bus.wb_flags = 0; bus.flush = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset state
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_sr", bus.sr, 0);
      chk("reset_wb_err", bus.wb_err, 0);
      chk("reset_out_exec", bus.out_exec, 0);

      // Writeback with nothing in flight: sticky error, sr loads c=1
      drive(0, 4'h0, 0, 1, 1, 4'b0100, 0);
      chk("wb_err_set", bus.wb_err, 1);
      chk("sr_load", bus.sr, 4'b0100);

      // Minimum latency: accept, hold, present at cycle 2, idle at cycle 3
      drive(1, 4'h2, 0, 1, 0, 4'h0, 0);
      chk("lat_cycle1_out_valid", bus.out_valid, 0);
      idle(1, 1);
      chk("lat_cycle2_out_valid", bus.out_valid, 1);
      chk("lat_cycle2_out_exec", bus.out_exec, 1);
      idle(1, 1);
      chk("lat_cycle3_in_ready", bus.in_ready, 1);

      // Flag-setter in flight blocks a flag-reading condition until writeback
      drive(1, 4'hE, 1, 1, 0, 4'h0, 0); idle(2, 1);
      drive(1, 4'h0, 0, 1, 0, 4'h0, 0); idle(3, 1);
      chk("dep_stall", bus.out_valid, 0);
      drive(0, 4'h0, 0, 1, 1, 4'b1000, 0);
      idle(1, 1);
      chk("dep_release_valid", bus.out_valid, 1);
      chk("dep_release_exec", bus.out_exec, 1);
      idle(1, 1);

      // Capacity: three flag-setters outstanding stall a fourth
      for (int k = 0; k < MAXI; k++) begin
         drive(1, 4'hE, 1, 1, 0, 4'h0, 0); idle(2, 1);
      end
      drive(1, 4'hE, 1, 1, 0, 4'h0, 0); idle(3, 1);
      chk("cap_stall", bus.out_valid, 0);
      drive(0, 4'h0, 0, 1, 1, 4'b0001, 0);
      idle(3, 1);
      for (int k = 0; k < MAXI; k++) drive(0, 4'h0, 0, 1, 1, 4'b0010, 0);

      // Issue fire coincident with writeback at count 1 leaves count at 1
      drive(1, 4'hE, 1, 0, 0, 4'h0, 0); idle(2, 1);
      drive(1, 4'hE, 1, 0, 0, 4'h0, 0); idle(2, 0);
      drive(0, 4'h0, 0, 1, 1, 4'b0100, 0);
      drive(1, 4'h1, 0, 1, 0, 4'h0, 0); idle(3, 1);
      chk("simul_count_stall", bus.out_valid, 0);
      drive(0, 4'h0, 0, 1, 1, 4'b0000, 0);
      idle(3, 1);

      // Never-condition flag-setter annuls and claims no slot
      drive(1, 4'hF, 1, 1, 0, 4'h0, 0); idle(1, 1);
      chk("nv_out_exec", bus.out_exec, 0);
      chk("nv_out_set_flags", bus.out_set_flags, 0);
      idle(1, 1);
      drive(1, 4'h1, 0, 1, 0, 4'h0, 0); idle(1, 1);
      chk("nv_no_count", bus.out_valid, 1);
      idle(1, 1);

      // Flush while presenting with out_ready low, sr still loads
      drive(1, 4'hE, 1, 1, 0, 4'h0, 0); idle(2, 1);
      drive(1, 4'hE, 1, 0, 0, 4'h0, 0); idle(2, 0);
      drive(0, 4'h0, 0, 0, 1, 4'b0011, 1);
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_in_ready", bus.in_ready, 1);
      chk("flush_sr", bus.sr, 4'b0011);
      drive(1, 4'h0, 0, 1, 0, 4'h0, 0); idle(1, 1);
      chk("flush_count_zero", bus.out_valid, 1);
      idle(1, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit fl, wbv;
         bit [3:0] c;
         fl  = ($urandom_range(0, 99) < 2);
         wbv = !fl && ($urandom_range(0, 99) < 15);
         c   = ($urandom_range(0, 3) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
         drive($urandom_range(0, 99) < 60, c, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 70, wbv, 4'($urandom_range(0, 15)), fl);
      end

      // Drain: clear outstanding setters, let any held instruction issue
      drive(0, 4'h0, 0, 1, 0, 4'h0, 1);
      idle(10, 1);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
